// File: rtl/load_scheduler_pkg.sv
// rtl/load_scheduler_pkg.sv - shared types and constants for the ICB load scheduler
package load_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    // Fixed requester index map; also the ICB mux select encoding
    localparam int REQ_ACT      = 0;
    localparam int REQ_WGT      = 1;
    localparam int REQ_BIAS     = 2;
    localparam int REQ_OUT      = 3;
    localparam int NUM_LOAD_REQ = 4;

endpackage

// File: rtl/load_scheduler_if.sv
// rtl/load_scheduler_if.sv - loader request/grant/done handshake and owner select bundle
interface load_sched_if
    import load_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_LOAD_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] granted;
    logic               owner_valid;
    logic [IDX_W-1:0]   owner_idx;

    // Scheduler side: drives grants and the ICB mux select
    modport master (
        input  req,
        input  done,
        output granted,
        output owner_valid,
        output owner_idx
    );

    // Loader side
    modport slave (
        output req,
        output done,
        input  granted,
        input  owner_valid,
        input  owner_idx
    );
endinterface

// File: rtl/load_scheduler_rr_arbiter.sv
// rtl/load_scheduler_rr_arbiter.sv - combinational rotating-priority picker
module rr_arbiter
    import load_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_LOAD_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_pos;

    // Scan from i_rr_ptr upward with wrap-around; the first set request wins
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_gnt_idx    = w_pos;
            end
        end
    end

endmodule

// File: rtl/load_scheduler.sv
// rtl/load_scheduler.sv - round-robin owner scheduler for the shared ICB master path
module load_scheduler
    import load_sched_pkg::*;
#(
    parameter int NUM_REQ   = NUM_LOAD_REQ,
    parameter int TIMEOUT_W = 16,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_init_cfg,
    input  logic [TIMEOUT_W-1:0] i_cfg_timeout,
    load_sched_if.master         bus,
    output logic                 o_timeout_err,
    output logic [IDX_W-1:0]     o_timeout_idx,
    output logic                 o_spurious_done
);

    sched_state_t         r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [TIMEOUT_W-1:0] r_cfg;
    logic [NUM_REQ-1:0]   r_granted;
    logic                 r_owner_valid;
    logic [IDX_W-1:0]     r_owner_idx;
    logic                 r_timeout_err;
    logic [IDX_W-1:0]     r_timeout_idx;
    logic                 r_spurious;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic                 w_any;
    logic [IDX_W-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0]   w_owner_oh;
    logic                 w_owner_done;
    logic                 w_timeout;
    logic                 w_spurious;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req     (bus.req),
        .i_rr_ptr  (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Pointer moves just past the winner so it is not re-picked until the scan wraps
    assign w_next_ptr   = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
    assign w_owner_oh   = NUM_REQ'(1) << r_owner_idx;
    assign w_owner_done = bus.done[r_owner_idx];
    assign w_timeout    = (r_cfg != '0) && (r_cnt == r_cfg - TIMEOUT_W'(1));
    assign w_spurious   = (r_state == IDLE) ? (|bus.done) : (|(bus.done & ~w_owner_oh));

    assign bus.granted     = r_granted;
    assign bus.owner_valid = r_owner_valid;
    assign bus.owner_idx   = r_owner_idx;
    assign o_timeout_err   = r_timeout_err;
    assign o_timeout_idx   = r_timeout_idx;
    assign o_spurious_done = r_spurious;

    // Ownership FSM: arbitration in IDLE, done/watchdog release in BUSY, config overlay last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_cfg         <= '0;
            r_granted     <= '0;
            r_owner_valid <= 1'b0;
            r_owner_idx   <= '0;
            r_timeout_err <= 1'b0;
            r_timeout_idx <= '0;
            r_spurious    <= 1'b0;
        end else begin
            r_granted <= '0;
            if (w_spurious) begin
                r_spurious <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_granted     <= w_gnt;
                        r_owner_valid <= 1'b1;
                        r_owner_idx   <= w_gnt_idx;
                        r_rr_ptr      <= w_next_ptr;
                        r_cnt         <= '0;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + TIMEOUT_W'(1);
                    if (w_owner_done) begin
                        // done beats a coincident watchdog expiry
                        r_owner_valid <= 1'b0;
                        r_state       <= IDLE;
                    end else if (w_timeout && !i_init_cfg) begin
                        // a reconfigure restarts the watchdog, so it never expires on that edge
                        r_owner_valid <= 1'b0;
                        r_state       <= IDLE;
                        r_timeout_err <= 1'b1;
                        if (!r_timeout_err) begin
                            r_timeout_idx <= r_owner_idx;
                        end
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_owner_valid <= 1'b0;
                end
            endcase
            // Reconfigure overrides pointer, count and sticky flags; ownership is untouched
            if (i_init_cfg) begin
                r_cfg         <= i_cfg_timeout;
                r_rr_ptr      <= '0;
                r_cnt         <= '0;
                r_timeout_err <= 1'b0;
                r_timeout_idx <= '0;
                r_spurious    <= 1'b0;
            end
        end
    end

endmodule
